// File: rtl/hub75_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : hub75_capture_if
// Brief    : HUB75 bus inputs and pixel-write / on-time outputs of the capture
//            block. The bus driver side uses master, the capture block slave.
// Revision : 1.0 - initial release
// ============================================================================
interface hub75_capture_if #(
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 6,
    parameter int ON_BITS  = 16
);
    logic [2:0]                   in_RGB0;
    logic [2:0]                   in_RGB1;
    logic                         in_SCREEN_CLOCK;
    logic [ROW_BITS-1:0]          in_ABCDE;
    logic                         in_LATCH;
    logic                         in_nOE;
    logic                         out_WE;
    logic [ROW_BITS+COL_BITS-1:0] out_ADDR;
    logic [5:0]                   out_DATA;
    logic                         out_ROW_DONE;
    logic                         out_ON_VALID;
    logic [ON_BITS-1:0]           out_ON_CYCLES;
    logic [ROW_BITS-1:0]          out_ON_ROW;
    logic                         out_OVERFLOW;
    logic                         out_UNDERRUN;
    logic                         out_LATCH_DROP;

    modport master (
        output in_RGB0, in_RGB1, in_SCREEN_CLOCK, in_ABCDE, in_LATCH, in_nOE,
        input  out_WE, out_ADDR, out_DATA, out_ROW_DONE, out_ON_VALID,
               out_ON_CYCLES, out_ON_ROW, out_OVERFLOW, out_UNDERRUN, out_LATCH_DROP
    );

    modport slave (
        input  in_RGB0, in_RGB1, in_SCREEN_CLOCK, in_ABCDE, in_LATCH, in_nOE,
        output out_WE, out_ADDR, out_DATA, out_ROW_DONE, out_ON_VALID,
               out_ON_CYCLES, out_ON_ROW, out_OVERFLOW, out_UNDERRUN, out_LATCH_DROP
    );
endinterface
`default_nettype wire

// File: rtl/hub75_capture.sv
`default_nettype none
// ============================================================================
// Module   : hub75_capture
// Brief    : HUB75 panel row-driver model: shifts, latches and replays a row
//            as pixel writes, and measures nOE low time per row.
// Revision : 1.0 - initial release
// ============================================================================
module hub75_capture #(
    parameter int COLS     = 64,
    parameter int COL_BITS = 6,
    parameter int ROW_BITS = 5,
    parameter int ON_BITS  = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    hub75_capture_if.slave  bus
);
    localparam int                  c_CNT_W    = COL_BITS + 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX  = c_CNT_W'(COLS + 1);
    localparam logic [c_CNT_W-1:0]  c_COLS     = c_CNT_W'(COLS);
    localparam logic [COL_BITS-1:0] c_LAST_COL = COL_BITS'(COLS - 1);
    localparam logic [ON_BITS-1:0]  c_ON_MAX   = '1;
    localparam int                  c_SYNC_W   = 9 + ROW_BITS;
    localparam logic [c_SYNC_W-1:0] c_SYNC_RST = c_SYNC_W'(1);

    typedef enum logic [0:0] {IDLE = 1'b0, DUMP = 1'b1} state_t;

    // Sync vector layout: {RGB1, RGB0, ABCDE, SCREEN_CLOCK, LATCH, nOE}
    logic [c_SYNC_W-1:0] r_s1, r_s2;
    logic [2:0]          r_h;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= c_SYNC_RST;
            r_s2 <= c_SYNC_RST;
            r_h  <= 3'b001;
        end else begin
            r_s1 <= {bus.in_RGB1, bus.in_RGB0, bus.in_ABCDE,
                     bus.in_SCREEN_CLOCK, bus.in_LATCH, bus.in_nOE};
            r_s2 <= r_s1;
            r_h  <= r_s2[2:0];
        end
    end

    logic                w_sclk_rise, w_latch_rise, w_noe_fall, w_noe_rise, w_noe_low;
    logic [5:0]          w_pix;
    logic [ROW_BITS-1:0] w_row;

    assign w_sclk_rise  =  r_s2[2] & ~r_h[2];
    assign w_latch_rise =  r_s2[1] & ~r_h[1];
    assign w_noe_fall   = ~r_s2[0] &  r_h[0];
    assign w_noe_rise   =  r_s2[0] & ~r_h[0];
    assign w_noe_low    = ~r_s2[0];
    assign w_pix        = r_s2[c_SYNC_W-1 -: 6];
    assign w_row        = r_s2[3 +: ROW_BITS];

    logic [5:0]         r_stage [COLS];
    logic [5:0]         r_hold  [COLS];
    logic [5:0]         w_stage_next [COLS];
    logic [c_CNT_W-1:0] r_shift_cnt, w_cnt_next;
    state_t             r_state;
    logic               w_accept;

    // Post-shift view so a same-cycle shift and latch hands hold the new row
    always_comb begin
        for (int i = 0; i < COLS; i++) w_stage_next[i] = r_stage[i];
        if (w_sclk_rise) begin
            for (int i = 0; i < COLS - 1; i++) w_stage_next[i] = r_stage[i + 1];
            w_stage_next[COLS - 1] = w_pix;
        end
    end

    assign w_cnt_next = (w_sclk_rise && r_shift_cnt != c_CNT_MAX)
                        ? r_shift_cnt + c_CNT_W'(1) : r_shift_cnt;
    assign w_accept   = w_latch_rise && (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < COLS; i++) r_stage[i] <= '0;
            r_shift_cnt <= '0;
        end else begin
            r_stage     <= w_stage_next;
            r_shift_cnt <= w_accept ? '0 : w_cnt_next;
        end
    end

    logic [ROW_BITS-1:0]          r_row_q;
    logic [COL_BITS-1:0]          r_col;
    logic                         r_issue_done;
    logic                         r_p1_we, r_p1_last;
    logic [ROW_BITS+COL_BITS-1:0] r_p1_addr, r_addr;
    logic [5:0]                   r_p1_data, r_data;
    logic                         r_we, r_row_done, r_overflow, r_underrun, r_latch_drop;

    // Hold is read through a registered stage; the FSM stays in DUMP until
    // the last write reaches the outputs so no latch can slip in early.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_row_q      <= '0;
            r_col        <= '0;
            r_issue_done <= 1'b0;
            for (int i = 0; i < COLS; i++) r_hold[i] <= '0;
            r_p1_we      <= 1'b0;
            r_p1_last    <= 1'b0;
            r_p1_addr    <= '0;
            r_p1_data    <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_row_done   <= 1'b0;
            r_overflow   <= 1'b0;
            r_underrun   <= 1'b0;
            r_latch_drop <= 1'b0;
        end else begin
            r_p1_we      <= 1'b0;
            r_p1_last    <= 1'b0;
            r_overflow   <= 1'b0;
            r_underrun   <= 1'b0;
            r_latch_drop <= 1'b0;
            r_we         <= r_p1_we;
            r_addr       <= r_p1_addr;
            r_data       <= r_p1_data;
            r_row_done   <= r_p1_last;
            case (r_state)
                IDLE: begin
                    if (w_latch_rise) begin
                        r_hold       <= w_stage_next;
                        r_row_q      <= w_row;
                        r_overflow   <= (w_cnt_next > c_COLS);
                        r_underrun   <= (w_cnt_next < c_COLS);
                        r_col        <= '0;
                        r_issue_done <= 1'b0;
                        r_state      <= DUMP;
                    end
                end
                DUMP: begin
                    if (w_latch_rise) r_latch_drop <= 1'b1;
                    if (!r_issue_done) begin
                        r_p1_we   <= 1'b1;
                        r_p1_addr <= {r_row_q, r_col};
                        r_p1_data <= r_hold[r_col];
                        r_p1_last <= (r_col == c_LAST_COL);
                        if (r_col == c_LAST_COL) r_issue_done <= 1'b1;
                        else                     r_col <= r_col + COL_BITS'(1);
                    end
                    if (r_p1_last) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic [ON_BITS-1:0]  r_on_cnt, r_on_cycles;
    logic [ROW_BITS-1:0] r_on_row, r_on_row_out;
    logic                r_on_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_on_cnt     <= '0;
            r_on_row     <= '0;
            r_on_cycles  <= '0;
            r_on_row_out <= '0;
            r_on_valid   <= 1'b0;
        end else begin
            r_on_valid <= 1'b0;
            if (w_noe_fall) begin
                r_on_cnt <= ON_BITS'(1);
                r_on_row <= r_row_q;
            end else if (w_noe_low && r_on_cnt != c_ON_MAX) begin
                r_on_cnt <= r_on_cnt + ON_BITS'(1);
            end
            if (w_noe_rise) begin
                r_on_cycles  <= r_on_cnt;
                r_on_row_out <= r_on_row;
                r_on_valid   <= 1'b1;
            end
        end
    end

    assign bus.out_WE         = r_we;
    assign bus.out_ADDR       = r_addr;
    assign bus.out_DATA       = r_data;
    assign bus.out_ROW_DONE   = r_row_done;
    assign bus.out_ON_VALID   = r_on_valid;
    assign bus.out_ON_CYCLES  = r_on_cycles;
    assign bus.out_ON_ROW     = r_on_row_out;
    assign bus.out_OVERFLOW   = r_overflow;
    assign bus.out_UNDERRUN   = r_underrun;
    assign bus.out_LATCH_DROP = r_latch_drop;
endmodule
`default_nettype wire

// File: tb/tb_hub75_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_capture
// Brief    : Scoreboard bench for hub75_capture: directed rows, flags, on-time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hub75_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hub75_capture_if #(.ROW_BITS(5), .COL_BITS(6), .ON_BITS(16)) bus ();

    hub75_capture #(.COLS(64), .COL_BITS(6), .ROW_BITS(5), .ON_BITS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [10:0] addr;
        logic [5:0]  data;
        logic        last;
    } wr_t;

    typedef struct packed {
        logic [15:0] cycles;
        logic [4:0]  row;
    } on_t;

    wr_t sb_wr [$];
    on_t sb_on [$];
    int  total = 0;
    int  bad   = 0;
    int  n_we = 0, n_over = 0, n_under = 0, n_drop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        on_t o;
        if (bus.out_WE) begin
            n_we++;
            if (sb_wr.size() == 0) begin
                check("unexpected_write", 64'(sb_wr.size()), 64'd1);
            end else begin
                e = sb_wr.pop_front();
                check("wr_addr", 64'(bus.out_ADDR), 64'(e.addr));
                check("wr_data", 64'(bus.out_DATA), 64'(e.data));
                check("row_done", 64'(bus.out_ROW_DONE), 64'(e.last));
            end
        end else if (bus.out_ROW_DONE) begin
            check("row_done_no_we", 64'(bus.out_WE), 64'd1);
        end
        if (bus.out_ON_VALID) begin
            if (sb_on.size() == 0) begin
                check("unexpected_on", 64'(sb_on.size()), 64'd1);
            end else begin
                o = sb_on.pop_front();
                check("on_cycles", 64'(bus.out_ON_CYCLES), 64'(o.cycles));
                check("on_row", 64'(bus.out_ON_ROW), 64'(o.row));
            end
        end
        if (bus.out_OVERFLOW)   n_over++;
        if (bus.out_UNDERRUN)   n_under++;
        if (bus.out_LATCH_DROP) n_drop++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_pix(input logic [5:0] p);
        bus.in_RGB0 = p[2:0];
        bus.in_RGB1 = p[5:3];
        cyc(2);
        bus.in_SCREEN_CLOCK = 1'b1;
        cyc(2);
        bus.in_SCREEN_CLOCK = 1'b0;
    endtask

    task automatic latch(input logic [4:0] row);
        bus.in_ABCDE = row;
        cyc(2);
        bus.in_LATCH = 1'b1;
        cyc(2);
        bus.in_LATCH = 1'b0;
        cyc(2);
    endtask

    task automatic push_wr(input logic [4:0] row, input int col, input logic [5:0] d);
        sb_wr.push_back('{addr: {row, 6'(col)}, data: d, last: (col == 63)});
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (sb_wr.size() == 0 && sb_on.size() == 0 && !bus.out_WE) begin
                cyc(3);
                return;
            end
            @(negedge clk);
        end
        check(name, 64'(sb_wr.size() + sb_on.size()), 64'd0);
        sb_wr.delete();
        sb_on.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {20'd0, bus.out_WE, bus.out_ADDR, bus.out_DATA, bus.out_ROW_DONE,
                     bus.out_ON_VALID, bus.out_ON_CYCLES, bus.out_ON_ROW,
                     bus.out_OVERFLOW, bus.out_UNDERRUN, bus.out_LATCH_DROP}, 64'd0);
    endtask

    initial begin
        int we0, ov0, un0, dr0, lat;
        bit found;
        bus.in_RGB0 = '0; bus.in_RGB1 = '0; bus.in_SCREEN_CLOCK = 1'b0;
        bus.in_ABCDE = '0; bus.in_LATCH = 1'b0; bus.in_nOE = 1'b1;
        cyc(3);
        check_idle_outputs("reset_outputs");
        rst = 1'b0;
        cyc(2);

        // Row 1: full 64-pixel row, data = col mod 8 in both halves, row 5
        we0 = n_we; ov0 = n_over; un0 = n_under; dr0 = n_drop;
        for (int c = 0; c < 64; c++) begin
            shift_pix({3'(c % 8), 3'(c % 8)});
            push_wr(5'd5, c, {3'(c % 8), 3'(c % 8)});
        end
        bus.in_ABCDE = 5'd5;
        cyc(2);
        bus.in_LATCH = 1'b1;
        found = 1'b0;
        lat = 0;
        for (int k = 1; k <= 12 && !found; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_WE) begin
                found = 1'b1;
                lat = k - 1;
            end
        end
        check("latch_latency", 64'(lat), 64'd4);
        bus.in_LATCH = 1'b0;
        wait_drain("drain_row1");
        check("row1_writes", 64'(n_we - we0), 64'd64);
        check("row1_flags", 64'((n_over - ov0) + (n_under - un0) + (n_drop - dr0)), 64'd0);

        // Row 2: 70 shifts, column c holds pixel c+6
        we0 = n_we; ov0 = n_over;
        for (int k = 0; k < 70; k++) shift_pix(6'(k));
        for (int c = 0; c < 64; c++) push_wr(5'd9, c, 6'(c + 6));
        latch(5'd9);
        wait_drain("drain_overflow");
        check("overflow_pulses", 64'(n_over - ov0), 64'd1);
        check("overflow_writes", 64'(n_we - we0), 64'd64);

        // Row 3: reset, then only 10 pixels
        rst = 1'b1;
        cyc(2);
        check_idle_outputs("reset2_outputs");
        rst = 1'b0;
        cyc(2);
        we0 = n_we; un0 = n_under;
        for (int k = 0; k < 10; k++) shift_pix(6'(k + 40));
        for (int c = 0; c < 64; c++) push_wr(5'd17, c, (c >= 54) ? 6'(c - 54 + 40) : 6'd0);
        latch(5'd17);
        wait_drain("drain_underrun");
        check("underrun_pulses", 64'(n_under - un0), 64'd1);
        check("underrun_writes", 64'(n_we - we0), 64'd64);

        // Row 4: latch, second latch during dump dropped, third latch dumps again
        for (int c = 0; c < 64; c++) shift_pix(6'(63 - c));
        we0 = n_we; ov0 = n_over; un0 = n_under; dr0 = n_drop;
        for (int c = 0; c < 64; c++) push_wr(5'd2, c, 6'(63 - c));
        latch(5'd2);
        cyc(14);
        latch(5'd4);
        wait_drain("drain_drop");
        check("drop_pulses", 64'(n_drop - dr0), 64'd1);
        check("drop_writes", 64'(n_we - we0), 64'd64);
        check("drop_no_flags", 64'((n_over - ov0) + (n_under - un0)), 64'd0);
        we0 = n_we;
        for (int c = 0; c < 64; c++) push_wr(5'd6, c, 6'(63 - c));
        latch(5'd6);
        wait_drain("drain_third");
        check("third_writes", 64'(n_we - we0), 64'd64);
        check("third_underrun", 64'(n_under - un0), 64'd1);

        // On-time: latch row 3, then nOE low 100 and 70000 cycles
        for (int c = 0; c < 64; c++) push_wr(5'd3, c, 6'(63 - c));
        latch(5'd3);
        wait_drain("drain_row3");
        sb_on.push_back('{cycles: 16'd100, row: 5'd3});
        bus.in_nOE = 1'b0;
        cyc(100);
        bus.in_nOE = 1'b1;
        cyc(2);
        wait_drain("on_short_timeout");
        sb_on.push_back('{cycles: 16'hFFFF, row: 5'd3});
        bus.in_nOE = 1'b0;
        cyc(70000);
        bus.in_nOE = 1'b1;
        cyc(2);
        wait_drain("on_long_timeout");

        // Reset in the middle of a dump, at column 30
        for (int c = 0; c < 64; c++) begin
            shift_pix(6'(c) ^ 6'h2A);
            push_wr(5'd11, c, 6'(c) ^ 6'h2A);
        end
        latch(5'd11);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.out_WE && bus.out_ADDR[5:0] == 6'd30) found = 1'b1;
        end
        check("reach_col30", 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb_wr.delete();
        check_idle_outputs("abort_outputs");
        cyc(1);
        rst = 1'b0;
        we0 = n_we;
        cyc(10);
        check("abort_no_writes", 64'(n_we - we0), 64'd0);

        ov0 = n_over; un0 = n_under;
        for (int c = 0; c < 64; c++) begin
            shift_pix(6'(c * 5));
            push_wr(5'd20, c, 6'(c * 5));
        end
        latch(5'd20);
        wait_drain("drain_after_abort");
        check("after_abort_writes", 64'(n_we - we0), 64'd64);
        check("after_abort_flags", 64'((n_over - ov0) + (n_under - un0)), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
